// File: rtl/seq_subtractor_32.sv
// -----------------------------------------------------------------------------
// seq_subtractor_32
//
// Purpose:
//    Multi-cycle subtractor. Computes diff = a - b as a + ~b + 1 by reusing a
//    single SLICE-wide ripple-carry adder over WIDTH/SLICE cycles. The least
//    significant slice is processed first. The carry is kept in a register
//    between cycles. Operands enter through a valid/ready handshake. The
//    result leaves through a second valid/ready handshake. This gives up
//    latency to save area compared with a full-width combinational adder.
//
// Ports:
//    clk        in   1      single clock, all state on rising edge
//    rst_n      in   1      asynchronous active-low reset (sync release upstream)
//    in_valid   in   1      operands a, b valid
//    in_ready   out  1      block can accept operands (high only when idle)
//    a          in   WIDTH  minuend (unsigned or two's complement)
//    b          in   WIDTH  subtrahend
//    out_valid  out  1      diff/borrow valid
//    out_ready  in   1      consumer accepts result
//    diff       out  WIDTH  a - b modulo 2^WIDTH
//    borrow     out  1      1 when unsigned a < b (inverted final carry)
//    overflow   out  1      signed overflow of a - b (only with SUB_OVERFLOW_FLAG_EN)
//
// Configuration macro:
//    SUB_OVERFLOW_FLAG_EN  - when defined, adds the 'overflow' output port and
//                            its register; otherwise neither exists.
//
// Parameters:
//    WIDTH  operand/result width, must be an integer multiple of SLICE
//    SLICE  bits processed per cycle
// -----------------------------------------------------------------------------
module seq_subtractor_32 #(
   parameter int WIDTH = 32,
   parameter int SLICE = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
`ifdef SUB_OVERFLOW_FLAG_EN
   ,
   output logic             overflow
`endif
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_CALC = 2'b01;
   localparam logic [1:0] S_DONE = 2'b10;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   // One slice of the ripple-carry adder. Bit SLICE of the result is the carry-out.
   function automatic logic [SLICE:0] slice_add(
      input logic [SLICE-1:0] x,
      input logic [SLICE-1:0] y,
      input logic             cin
   );
      logic [SLICE:0] s;
      s = {1'b0, x} + {1'b0, y} + {{SLICE{1'b0}}, cin};
      return s;
   endfunction

   logic [1:0]       state_q,     state_d;
   logic [WIDTH-1:0] a_q,         a_d;
   logic [WIDTH-1:0] nb_q,        nb_d;      // subtrahend stored already inverted
   logic [WIDTH-1:0] diff_q,      diff_d;
   logic             carry_q,     carry_d;
   logic [IDX_W-1:0] idx_q,       idx_d;
   logic             borrow_q,    borrow_d;
   logic             in_ready_q,  in_ready_d;
   logic             out_valid_q, out_valid_d;
`ifdef SUB_OVERFLOW_FLAG_EN
   logic             overflow_q,  overflow_d;
`endif

   logic [SLICE-1:0] a_slice_s;
   logic [SLICE-1:0] nb_slice_s;
   logic [SLICE:0]   sum_s;
   logic             last_slice_s;

   // Select the operand slices for the current index and add them with the running carry.
   always_comb begin
      a_slice_s    = a_q[idx_q*SLICE +: SLICE];
      nb_slice_s   = nb_q[idx_q*SLICE +: SLICE];
      sum_s        = slice_add(a_slice_s, nb_slice_s, carry_q);
      last_slice_s = (idx_q == LAST_IDX);
   end

   // Next-state logic for the FSM and datapath registers.
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      nb_d     = nb_q;
      diff_d   = diff_q;
      carry_d  = carry_q;
      idx_d    = idx_q;
      borrow_d = borrow_q;
`ifdef SUB_OVERFLOW_FLAG_EN
      overflow_d = overflow_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready_q) begin
               a_d     = a;
               nb_d    = ~b;
               // A carry-in of 1 supplies the +1 of the two's complement.
               carry_d = 1'b1;
               idx_d   = '0;
               state_d = S_CALC;
            end else begin
               state_d = S_IDLE;
            end
         end

         S_CALC: begin
            diff_d[idx_q*SLICE +: SLICE] = sum_s[SLICE-1:0];
            carry_d = sum_s[SLICE];
            if (last_slice_s) begin
               // A final carry-out of 0 means a < b when both are read as unsigned.
               borrow_d = ~sum_s[SLICE];
`ifdef SUB_OVERFLOW_FLAG_EN
               // The signs of a and b differ exactly when a[msb] equals ~b[msb].
               // Overflow occurs if the result sign then differs from a's sign.
               overflow_d = (a_q[WIDTH-1] == nb_q[WIDTH-1]) &&
                            (sum_s[SLICE-1] != a_q[WIDTH-1]);
`endif
               idx_d    = '0;
               state_d  = S_DONE;
            end else begin
               idx_d    = idx_q + IDX_ONE;
               state_d  = S_CALC;
            end
         end

         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DONE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Handshake flags are decoded from the next state so that they are registered outputs.
      in_ready_d  = (state_d == S_IDLE);
      out_valid_d = (state_d == S_DONE);
   end

   // State and datapath registers, cleared by the asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         a_q         <= '0;
         nb_q        <= '0;
         diff_q      <= '0;
         carry_q     <= 1'b0;
         idx_q       <= '0;
         borrow_q    <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
`ifdef SUB_OVERFLOW_FLAG_EN
         overflow_q  <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         nb_q        <= nb_d;
         diff_q      <= diff_d;
         carry_q     <= carry_d;
         idx_q       <= idx_d;
         borrow_q    <= borrow_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
`ifdef SUB_OVERFLOW_FLAG_EN
         overflow_q  <= overflow_d;
`endif
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign diff      = diff_q;
   assign borrow    = borrow_q;
`ifdef SUB_OVERFLOW_FLAG_EN
   assign overflow  = overflow_q;
`endif

endmodule

// File: tb/tb_seq_subtractor_32.sv
// -----------------------------------------------------------------------------
// tb_seq_subtractor_32
//
// Purpose:
//    Self-checking bench for seq_subtractor_32. Expected results come from
//    plain full-width arithmetic on the operands.
// -----------------------------------------------------------------------------
module tb_seq_subtractor_32;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] diff;
   logic        borrow;
`ifdef SUB_OVERFLOW_FLAG_EN
   logic        overflow;
`endif

   int checks_total  = 0;
   int checks_passed = 0;

   always #5 clk = ~clk;

   seq_subtractor_32 #(.WIDTH(32), .SLICE(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .borrow    (borrow)
`ifdef SUB_OVERFLOW_FLAG_EN
      ,
      .overflow  (overflow)
`endif
   );

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks_total++;
      assert (obs === exp) checks_passed++;
      else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      checks_total++;
      assert (obs === exp) checks_passed++;
      else $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
   endtask

   // Run one subtraction. Hold back out_ready for 'hold' cycles while
   // presenting junk operands, which must be ignored.
   task automatic do_op(input logic [31:0] av, input logic [31:0] bv, input int hold);
      logic [31:0] ed;
      logic        eb;
      logic        eo;
      int          lat;
      logic        stable;
      ed = av - bv;
      eb = (av < bv);
      eo = (av[31] != bv[31]) && (ed[31] != av[31]);

      @(negedge clk);
      check1("in_ready_idle", in_ready, 1'b1);
      a = av;
      b = bv;
      in_valid = 1'b1;
      @(negedge clk);              // handshake happened on the posedge in between
      in_valid = 1'b0;
      a = $urandom;
      b = $urandom;
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check32("latency", 32'(lat), 32'd5);
      check1("out_valid", out_valid, 1'b1);
      check32("diff", diff, ed);
      check1("borrow", borrow, eb);
`ifdef SUB_OVERFLOW_FLAG_EN
      check1("overflow", overflow, eo);
`endif
      check1("in_ready_busy", in_ready, 1'b0);

      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         a = $urandom;
         b = $urandom;
         @(negedge clk);
         if (diff !== ed || borrow !== eb || out_valid !== 1'b1 || in_ready !== 1'b0)
            stable = 1'b0;
      end
      if (hold > 0) check1("hold_stable", stable, 1'b1);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check1("out_valid_drop", out_valid, 1'b0);
      check1("in_ready_back", in_ready, 1'b1);
      check32("diff_held", diff, ed);
      check1("borrow_held", borrow, eb);
   endtask

   initial begin
      logic ov_quiet;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = 32'h0;
      b         = 32'h0;

      // Reset values
      repeat (2) @(negedge clk);
      check1("rst_in_ready", in_ready, 1'b1);
      check1("rst_out_valid", out_valid, 1'b0);
      check32("rst_diff", diff, 32'h0);
      check1("rst_borrow", borrow, 1'b0);
`ifdef SUB_OVERFLOW_FLAG_EN
      check1("rst_overflow", overflow, 1'b0);
`endif
      rst_n = 1'b1;

      // Directed cases
      do_op(32'h0000_0010, 32'h0000_0001, 0);
      do_op(32'h0000_0000, 32'h0000_0001, 2);
      do_op(32'hDEAD_BEEF, 32'hDEAD_BEEF, 0);
      do_op(32'h8000_0000, 32'h0000_0001, 1);
      do_op(32'h1234_5678, 32'h0000_0000, 0);
      do_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 0);
      do_op(32'h0000_00FF, 32'h0000_0100, 0);   // borrow ripples across a slice boundary
      do_op(32'h1234_5678, 32'h9ABC_DEF0, 10);  // long backpressure

      // Reset during the second CALC cycle aborts the operation
      @(negedge clk);
      a = 32'hCAFE_F00D;
      b = 32'h0BAD_BEEF;
      in_valid = 1'b1;
      @(negedge clk);              // CALC cycle 1
      in_valid = 1'b0;
      @(negedge clk);              // CALC cycle 2
      #1 rst_n = 1'b0;
      #1;
      check1("midrst_in_ready", in_ready, 1'b1);
      check1("midrst_out_valid", out_valid, 1'b0);
      check32("midrst_diff", diff, 32'h0);
      check1("midrst_borrow", borrow, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      ov_quiet = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (out_valid !== 1'b0) ov_quiet = 1'b0;
      end
      check1("midrst_no_result", ov_quiet, 1'b1);
      do_op(32'h0000_0005, 32'h0000_0003, 0);

      // Randomized operands against the arithmetic model
      for (int n = 0; n < 24; n++) begin
         do_op($urandom, $urandom, int'($urandom_range(0, 3)));
      end

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

   // Global time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
